// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use, redirect and memory-wait stall/flush control for a 5-stage MIPS pipe
// Ports: clock/reset (async, active-high); id_rs/id_rt/id_uses_rt describe the IF/ID reader;
// ex_mem_read/ex_write_reg describe the ID/EX load; mem_branch_taken/mem_jump/mem_req/mem_ready
// come from EX/MEM and data memory; *_en and *_flush drive the pipeline registers; mem_err is the
// sticky watchdog trap. Macro HAZARD_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_write_reg,
  input  logic       mem_branch_taken,
  input  logic       mem_jump,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP} state_t;
  state_t state;
  logic [7:0] wcnt;
  logic live, mwait, redirect, load_use, go;
  assign live = !reset && state != TRAP;
  assign mwait = mem_req && !mem_ready;
  assign redirect = mem_branch_taken || mem_jump;
  assign load_use = ex_mem_read && ex_write_reg != 5'd0 &&
                    (ex_write_reg == id_rs || (id_uses_rt && ex_write_reg == id_rt));
  assign go = live && !mwait;
  // a redirect flushes the dependent instruction, so it overrides the load-use bubble
  assign pc_en = go && (redirect || !load_use);
  assign ifid_en = pc_en;
  assign idex_en = go;
  assign exmem_en = go;
  assign memwb_en = go;
  assign ifid_flush = go && redirect;
  assign idex_flush = go && (redirect || load_use);
  assign exmem_flush = go && redirect;
  assign mem_err = state == TRAP;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= RUN;
      wcnt <= 8'd0;
    end else if (state != TRAP) begin
      state <= mwait ? (wcnt == 8'(MEM_TIMEOUT - 1) ? TRAP : MEM_WAIT) : RUN;
      wcnt <= mwait ? wcnt + 8'd1 : 8'd0;
    end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(!pc_en && state != TRAP && !(&stall_cnt));
      flush_cnt <= flush_cnt + CNT_W'(ifid_flush && !(&flush_cnt));
    end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queue-based scoreboard for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clock = 0, reset = 1;
  logic [4:0] id_rs = 0, id_rt = 0, ex_write_reg = 0;
  logic id_uses_rt = 0, ex_mem_read = 0, mem_branch_taken = 0, mem_jump = 0, mem_req = 0, mem_ready = 0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, mem_err;
  int tests = 0, fails = 0;
  logic [8:0] eq[$];
  string nq[$];
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
  int es = 0, ef = 0;
`endif
  localparam logic [8:0] NORM = 9'b11111_000_0;
  localparam logic [8:0] LU   = 9'b00111_010_0;
  localparam logic [8:0] RED  = 9'b11111_111_0;
  localparam logic [8:0] FRZ  = 9'b00000_000_0;
  localparam logic [8:0] TRP  = 9'b00000_000_1;
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg), .mem_branch_taken(mem_branch_taken),
    .mem_jump(mem_jump), .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
  always #5 clock = ~clock;
  always @(negedge clock)
    if (eq.size() > 0) begin
      logic [8:0] e, a;
      string n;
      e = eq.pop_front();
      n = nq.pop_front();
      a = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, mem_err};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got %b expected %b", n, a, e);
      end
    end
  task automatic step(input string n, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mr, input logic [4:0] wr, input logic br,
                      input logic jp, input logic rq, input logic rdy, input logic [8:0] e);
    @(posedge clock);
    #1;
    reset = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mr; ex_write_reg = wr;
    mem_branch_taken = br; mem_jump = jp; mem_req = rq; mem_ready = rdy;
    eq.push_back(e);
    nq.push_back(n);
`ifdef HAZARD_PERF_CNT_EN
    if (r) begin es = 0; ef = 0; end
    else begin
      if (!e[8] && !e[0]) es++;
      if (e == RED) ef++;
    end
`endif
  endtask
  initial begin
    step("reset_hold", 1, 5, 5, 1, 1, 5, 1, 0, 1, 0, FRZ);
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
    step("load_use_rs", 0, 5, 1, 1, 1, 5, 0, 0, 0, 0, LU);
    step("load_use_clear", 0, 5, 1, 1, 0, 5, 0, 0, 0, 0, NORM);
    step("r0_no_stall", 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, NORM);
    step("rt_unused", 0, 3, 7, 0, 1, 7, 0, 0, 0, 0, NORM);
    step("rt_used", 0, 3, 7, 1, 1, 7, 0, 0, 0, 0, LU);
    step("redirect_over_lu", 0, 5, 5, 1, 1, 5, 1, 0, 0, 0, RED);
    step("jump", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RED);
    for (int i = 0; i < 3; i++) step("mem_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
    step("mem_ready", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NORM);
    step("ready_first", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NORM);
    step("wait_over_branch", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, FRZ);
    step("ready_with_branch", 0, 5, 0, 0, 1, 5, 1, 0, 1, 1, RED);
    for (int i = 0; i < 3; i++) step("wait_again", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
    step("req_drop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
    for (int i = 0; i < 4; i++) step("wd_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
    step("trap_ready", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, TRP);
    step("trap_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, TRP);
    step("trap_redirect", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, TRP);
    step("trap_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ);
    step("after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
    for (int i = 0; i < 2; i++) step("pre_reset_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
    step("reset_mid_wait", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
    for (int i = 0; i < 3; i++) step("post_reset_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
    step("post_reset_ready", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NORM);
    step("final_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
    @(posedge clock);
    #1;
`ifdef HAZARD_PERF_CNT_EN
    tests++;
    if (stall_cnt !== 16'(es)) begin fails++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, es); end
    tests++;
    if (flush_cnt !== 16'(ef)) begin fails++; $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt, ef); end
`endif
    for (int i = 0; i < 20 && eq.size() > 0; i++) @(posedge clock);
    if (eq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d vectors unchecked, expected 0", eq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the five-stage MIPS pipeline. Generates the per-register `enable` and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three conditions:
- load-use hazards, by inserting a one-cycle bubble;
- taken branches and jumps resolved in MEM, by flushing the three younger stages;
- multi-cycle data-memory accesses, by freezing the pipe until the memory handshake completes, with a watchdog.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 64: maximum consecutive wait cycles before the error trap; legal range 1..255.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `id_rs` in 5: rs field of the instruction in IF/ID.
- `id_rt` in 5: rt field of the instruction in IF/ID.
- `id_uses_rt` in 1: the IF/ID instruction reads rt.
- `ex_mem_read` in 1: ID/EX holds a load.
- `ex_write_reg` in 5: destination register of ID/EX.
- `mem_branch_taken` in 1: EX/MEM holds a branch with Zero=1.
- `mem_jump` in 1: EX/MEM holds a jump.
- `mem_req` in 1: EX/MEM holds a MemRead or MemWrite.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1: pipeline register enables.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1: the register loads all-zero (NOP, all controls 0) at the next edge. Each is only meaningful with its enable high.
- `mem_err` out 1: sticky watchdog error.
- `stall_cnt`, `flush_cnt` out `CNT_W`: present only with `HAZARD_PERF_CNT_EN`.

## Operation
- FSM states:
  - RUN (reset state).
  - MEM_WAIT.
  - TRAP.
- 8-bit wait counter `wcnt`.
- Outputs are combinational from inputs and state. State updates on `clock` rising edge.

Conditions are evaluated in priority order in RUN and MEM_WAIT:
1. Memory wait: `mem_req && !mem_ready`.
   - All five enables 0 and all flushes 0.
   - State goes to (or stays in) MEM_WAIT and `wcnt` increments.
2. Redirect: `mem_branch_taken || mem_jump`, with memory not waiting.
   - All enables 1.
   - `ifid_flush`, `idex_flush` and `exmem_flush` all 1.
   - PC loads the target.
   - Load-use detection is suppressed this cycle.
3. Load-use: `ex_mem_read && ex_write_reg != 0 && (ex_write_reg == id_rs || (id_uses_rt && ex_write_reg == id_rt))`.
   - `pc_en` 0 and `ifid_en` 0.
   - `idex_en` 1 with `idex_flush` 1 (bubble).
   - `exmem_en` 1 and `memwb_en` 1.
4. Otherwise: all enables 1, all flushes 0.

MEM_WAIT exit:
- When `mem_ready` is 1 (or `mem_req` drops), that same cycle follows rules 2–4.
- State returns to RUN and `wcnt` clears.

Watchdog:
- A wait cycle taken while `wcnt == MEM_TIMEOUT-1` moves the FSM to TRAP.
- TRAP: all enables 0, all flushes 0, `mem_err` 1.
- TRAP holds until `reset`; inputs are ignored.

Boundary cases:
- Register 0 never causes a load-use stall.
- A redirect while a load-use condition exists: the redirect wins. The dependent instruction is flushed, so no stall.
- `mem_ready` asserted in the first request cycle: no wait cycle, no state change.

## Timing
- Reset (asynchronous assert):
  - state RUN, `wcnt` 0, `mem_err` 0, counters 0.
  - While `reset` is high, all enables and flushes are forced to 0.
- Zero-cycle decision latency: outputs settle in the same cycle as their inputs.
- Load-use costs exactly 1 bubble cycle. The hazard clears on the next cycle because the load has advanced to EX/MEM.
- A redirect costs 3 flushed slots and lasts a single cycle.
- A memory wait of N cycles costs N freeze cycles; N ≤ `MEM_TIMEOUT`-1 to avoid TRAP.
- Reset asserted mid-MEM_WAIT or in TRAP: immediate return to RUN. The pipeline registers keep their contents; their own reset or initial values govern them.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` increments on every cycle with `pc_en` = 0 outside TRAP.
  - `flush_cnt` increments on every redirect cycle.
  - Both saturate at all-ones and clear on `reset`.
- Not defined: the counter ports and logic are absent.

## Test plan
- Load-use: ID/EX load writing r5 (`ex_mem_read`=1, `ex_write_reg`=5), `id_rs`=5 -> one cycle with `pc_en`=0, `ifid_en`=0, `idex_flush`=1. The next cycle (`ex_mem_read`=0) gives all enables 1. Repeat with `ex_write_reg`=0 -> no stall.
- Redirect priority: `mem_branch_taken`=1 together with a load-use condition -> all enables 1, all three flushes 1, `pc_en`=1; `flush_cnt` +1 when enabled.
- Memory wait: `mem_req`=1, `mem_ready`=0 for 3 cycles then 1 -> 3 cycles of all enables 0, then all enables 1 on the ready cycle, state RUN; `stall_cnt`=3 when enabled.
- Watchdog: `MEM_TIMEOUT`=4, `mem_ready` held at 0 -> `mem_err`=1 after the 4th wait cycle. Enables stay 0 even after `mem_ready`=1. `reset` clears `mem_err` and returns to RUN.
- Asynchronous reset mid-wait: assert `reset` between clock edges during MEM_WAIT -> enables 0 immediately; after release, RUN with `wcnt`=0.
- `id_uses_rt`=0, `ex_write_reg` == `id_rt` == 7, `id_rs` != 7, load in EX -> no stall.
